rsr_lane_scheduler: RTL
=======================

Name: rsr_lane_scheduler

Overview:
- Per-lane issue scheduler for an execution lane shared by simple (1-cycle) and complex (FU_LATENCY-cycle) instructions.
- Each cycle it grants at most one of the two requesters and owns the lane's result-slot reservation shift register (RSR).
- It broadcasts each granted destination tag for wakeup exactly when that instruction's result completes.
- It guarantees no writeback collision, prevents complex starvation and supports a non-pipelined complex unit.

Parameters:
- FU_LATENCY, 3, complex-op execute latency in cycles; legal range is 2 or more.
- PIPELINED, 1, 1 = complex unit accepts one op per cycle; 0 = unit is busy for FU_LATENCY cycles after each grant.
- STARVE_LIMIT, 4, consecutive denied complex-request cycles before complex gets priority; legal range 1–15.
- SIZE_PHYSICAL_LOG, `SIZE_PHYSICAL_LOG, physical register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- simpleReq_i  in  1  simple instruction requests issue this cycle.
- simpleTag_i  in  SIZE_PHYSICAL_LOG  destination tag of the simple request.
- simpleHasDest_i  in  1  the simple op writes a register.
- complexReq_i  in  1  complex instruction requests issue this cycle.
- complexTag_i  in  SIZE_PHYSICAL_LOG  destination tag of the complex request.
- complexHasDest_i  in  1  the complex op writes a register.
- flush_i  in  1  pipeline flush; cancels all in-flight reservations.
- simpleGrant_o  out  1  simple granted; combinational, same cycle.
- complexGrant_o  out  1  complex granted; combinational, same cycle.
- rsrTag_o  out  SIZE_PHYSICAL_LOG  wakeup tag being broadcast.
- rsrValid_o  out  1  rsrTag_o is valid this cycle.
- busy_o  out  1  non-pipelined complex unit is occupied; always 0 when PIPELINED=1.
- inflight_o  out  $clog2(FU_LATENCY+1)  number of valid RSR slots.

Behaviour:
- State:
  - RSR slots 0..FU_LATENCY-1, each holding {tag, valid}; slot 0 is the head.
  - busyCnt, range 0..FU_LATENCY-1.
  - starveCnt, 4 bits, saturating at STARVE_LIMIT.
- Outputs: rsrTag_o = slot0.tag, rsrValid_o = slot0.valid.
- Reset (reset=0, asynchronous): all slots clear (tag=0, valid=0), busyCnt=0, starveCnt=0.
  - Resulting outputs: rsrValid_o=0, rsrTag_o=0, busy_o=0, inflight_o=0.
  - Grants are 0 while reset is low.
  - Reset asserted mid-operation drops every pending broadcast; nothing is replayed.
- Eligibility, combinational:
  - simpleOK = simpleReq_i && !slot1.valid && !flush_i.
  - complexOK = complexReq_i && (busyCnt==0) && !flush_i.
- Arbitration:
  - If only one requester is OK, it is granted.
  - If both are OK, simple wins unless starveCnt==STARVE_LIMIT, in which case complex wins.
  - simpleGrant_o and complexGrant_o are never both 1.
- RSR update, every clock edge when not flushing:
  - slot[FU_LATENCY-1] <= {complexTag_i, complexGrant_o && complexHasDest_i}.
  - slot[i] <= slot[i+1] for 1 <= i < FU_LATENCY-1.
  - slot0 <= {simpleTag_i, 1} if simpleGrant_o && simpleHasDest_i; otherwise slot0 <= slot1.
- Resulting latency: a simple grant at cycle t broadcasts at t+1; a complex grant at t broadcasts at t+FU_LATENCY.
- Collision freedom: simple is blocked whenever slot1.valid, so the head is never claimed twice.
  - A simple op with no destination is still blocked by slot1.valid, because the result bus is shared.
- Non-pipelined mode (PIPELINED=0):
  - A complex grant loads busyCnt=FU_LATENCY-1.
  - busyCnt decrements by 1 per cycle while nonzero.
  - busy_o = (busyCnt!=0).
  - A back-to-back complex grant is therefore possible only FU_LATENCY cycles apart.
- Starvation counter:
  - Cleared on complex grant or when complexReq_i=0.
  - Otherwise incremented by 1 (saturating at STARVE_LIMIT) when complexReq_i && !complexGrant_o.
  - A complex request denied because busy_o=1 also increments it.
- inflight_o is the registered popcount of the slot valids.
- flush_i=1:
  - No grants that cycle.
  - On the next edge: all slots are invalidated, busyCnt=0, starveCnt=0.
  - The broadcast in the flush cycle itself (current slot0) is still driven.
- Simultaneous flush_i and reset: reset dominates.

Test Plan:
- Reset with FU_LATENCY=3, then simpleReq_i=1, tag 0x05, dest=1 at cycle 1 → simpleGrant_o=1 in cycle 1; rsrValid_o=1 with rsrTag_o=0x05 in cycle 2 only.
- complexReq_i=1, tag 0x11 at cycle 1 alone → complexGrant_o=1; broadcast 0x11 in cycle 4; in cycle 3 (slot1 valid) simpleReq_i is denied.
- Both requests every cycle, STARVE_LIMIT=2, no slot1 conflict:
  - Cycles 1–2: simple wins; starveCnt goes 1 then 2.
  - Cycle 3: complex wins; starveCnt returns to 0.
  - No cycle ever has rsrValid_o sourced from two grants.
- PIPELINED=0, complexReq_i held high → grants at cycles 1, 4, 7; busy_o=1 in cycles 2–3 and 5–6.
- Complex grant at cycle 1 and simple grant at cycle 2, then flush_i=1 in cycle 2 → no grant in cycle 2; rsrValid_o=0 in cycles 3–5; inflight_o=0 from cycle 3.
- Reset driven low asynchronously mid-cycle with 2 slots valid → rsrValid_o and inflight_o drop to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rsr_lane_scheduler.sv
// rsr_lane_scheduler
//   Per-lane issue scheduler shared by a 1-cycle simple path and a
//   FU_LATENCY-cycle complex path. Grants at most one requester per cycle,
//   owns the lane's result-slot reservation shift register (RSR) and
//   broadcasts each granted destination tag when its result completes.
//
// Ports
//   clk               clock, rising edge
//   reset             asynchronous, active-low reset
//   simpleReq_i       simple op requests issue
//   simpleTag_i       simple op destination tag
//   simpleHasDest_i   simple op writes a register
//   complexReq_i      complex op requests issue
//   complexTag_i      complex op destination tag
//   complexHasDest_i  complex op writes a register
//   flush_i           cancel all in-flight reservations
//   simpleGrant_o     simple granted (combinational)
//   complexGrant_o    complex granted (combinational)
//   rsrTag_o          wakeup tag broadcast (RSR head)
//   rsrValid_o        rsrTag_o valid
//   busy_o            non-pipelined complex unit occupied
//   inflight_o        number of valid RSR slots

`ifndef SIZE_PHYSICAL_LOG
`define SIZE_PHYSICAL_LOG 7
`endif

module rsr_lane_scheduler #(
    parameter int FU_LATENCY        = 3,
    parameter int PIPELINED         = 1,
    parameter int STARVE_LIMIT      = 4,
    parameter int SIZE_PHYSICAL_LOG = `SIZE_PHYSICAL_LOG
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               simpleReq_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]       simpleTag_i,
    input  logic                               simpleHasDest_i,
    input  logic                               complexReq_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]       complexTag_i,
    input  logic                               complexHasDest_i,
    input  logic                               flush_i,
    output logic                               simpleGrant_o,
    output logic                               complexGrant_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]       rsrTag_o,
    output logic                               rsrValid_o,
    output logic                               busy_o,
    output logic [$clog2(FU_LATENCY+1)-1:0]    inflight_o
);

    localparam int CW = $clog2(FU_LATENCY + 1);

    logic [SIZE_PHYSICAL_LOG-1:0] slot_tag [FU_LATENCY];
    logic [FU_LATENCY-1:0]        slot_valid;
    logic [FU_LATENCY-1:0]        valid_next;
    logic [CW-1:0]                busy_cnt;
    logic [3:0]                   starve_cnt;
    logic [CW-1:0]                inflight_q;
    logic                         simple_ok;
    logic                         complex_ok;
    logic                         complex_first;

    function automatic logic [CW-1:0] popcount(input logic [FU_LATENCY-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < FU_LATENCY; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // A simple op lands in the head slot one cycle after grant, which is
    // exactly where slot1 is heading; simple must yield to any reservation
    // there even when it has no destination, since the result bus is shared.
    always_comb begin
        simple_ok      = reset && simpleReq_i && !slot_valid[1] && !flush_i;
        complex_ok     = reset && complexReq_i && (busy_cnt == '0) && !flush_i;
        complex_first  = (starve_cnt == 4'(STARVE_LIMIT));
        complexGrant_o = complex_ok && (!simple_ok || complex_first);
        simpleGrant_o  = simple_ok && !complexGrant_o;
    end

    always_comb begin
        valid_next = '0;
        if (!flush_i) begin
            valid_next[FU_LATENCY-1] = complexGrant_o && complexHasDest_i;
            for (int unsigned i = 1; i < FU_LATENCY - 1; i++) begin
                valid_next[i] = slot_valid[i+1];
            end
            valid_next[0] = (simpleGrant_o && simpleHasDest_i) ? 1'b1 : slot_valid[1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FU_LATENCY; i++) begin
                slot_tag[i] <= '0;
            end
            slot_valid <= '0;
            busy_cnt   <= '0;
            starve_cnt <= '0;
            inflight_q <= '0;
        end else begin
            slot_valid <= valid_next;
            inflight_q <= popcount(valid_next);
            if (flush_i) begin
                busy_cnt   <= '0;
                starve_cnt <= '0;
            end else begin
                slot_tag[FU_LATENCY-1] <= complexTag_i;
                for (int unsigned i = 1; i < FU_LATENCY - 1; i++) begin
                    slot_tag[i] <= slot_tag[i+1];
                end
                slot_tag[0] <= (simpleGrant_o && simpleHasDest_i) ? simpleTag_i : slot_tag[1];

                if ((PIPELINED == 0) && complexGrant_o) begin
                    busy_cnt <= CW'(FU_LATENCY - 1);
                end else if (busy_cnt != '0) begin
                    busy_cnt <= busy_cnt - 1'b1;
                end

                if (complexGrant_o || !complexReq_i) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != 4'(STARVE_LIMIT)) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end
        end
    end

    assign rsrTag_o   = slot_tag[0];
    assign rsrValid_o = slot_valid[0];
    assign busy_o     = (busy_cnt != '0);
    assign inflight_o = inflight_q;

endmodule
